// File: rtl/riscv_mem_arbiter_pkg.sv
// riscv_mem_pkg: shared owner type and word/byte-enable constants for the memory arbiter
package riscv_mem_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W = WORD_W / 8;
  localparam logic [BE_W-1:0] BE_NONE = '0;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} mem_owner_t;
endpackage

// File: rtl/riscv_mem_arbiter_grant.sv
// mem_arb_grant: D-priority two-requester grant with a starvation guard for I
//   clk, rst_n    clock, asynchronous active-low reset
//   i_req, d_req  requests (I = fetch, D = load/store)
//   ready         target can accept an access this cycle
//   i_gnt, d_gnt  one-hot (or zero) same-cycle grants
module mem_arb_grant #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic d_req,
  input  logic ready,
  output logic i_gnt,
  output logic d_gnt
);
  localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);
  logic [3:0] streak_q, streak_d;
  logic force_i;
  // streak counts D wins while I waits; at the limit I takes the next slot
  always_comb begin
    force_i = i_req && streak_q == MAX_S;
    d_gnt = rst_n && ready && d_req && !force_i;
    i_gnt = rst_n && ready && i_req && !d_gnt;
    streak_d = (!i_req || i_gnt) ? 4'd0 :
               (d_gnt && streak_q != MAX_S) ? streak_q + 4'd1 : streak_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) streak_q <= 4'd0;
    else streak_q <= streak_d;
endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one single-port synchronous RAM between fetch (I) and load/store (D)
//   clk, rst_n                    clock, asynchronous active-low reset
//   i_req/i_addr/i_gnt            fetch request, byte address, accept
//   i_rvalid/i_rdata              fetch response, one cycle after i_gnt
//   d_req/d_we/d_be/d_addr/d_wdata load/store request
//   d_gnt, d_rvalid/d_rdata       accept, load response one cycle after a read grant
//   mem_ready                     RAM can take an access this cycle
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  RAM port
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 12,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  input  logic              mem_ready,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  mem_owner_t owner_q, owner_d;
  logic unused_addr;
  mem_arb_grant #(.MAX_D_STREAK(MAX_D_STREAK)) u_grant (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .d_req(d_req),
    .ready(mem_ready), .i_gnt(i_gnt), .d_gnt(d_gnt)
  );
  // owner_q remembers who issued last cycle's read so the RAM's 1-cycle data is routed back;
  // rdata is forced to zero when not valid
  always_comb begin
    mem_en = i_gnt || d_gnt;
    mem_we = (d_gnt && d_we) ? d_be : BE_NONE;
    mem_addr = d_gnt ? d_addr[MEM_AW+1:2] : i_addr[MEM_AW+1:2];
    mem_wdata = d_wdata;
    owner_d = i_gnt ? OWN_I : (d_gnt && !d_we) ? OWN_D : OWN_NONE;
    i_rvalid = owner_q == OWN_I;
    d_rvalid = owner_q == OWN_D;
    i_rdata = i_rvalid ? mem_rdata : '0;
    d_rdata = d_rvalid ? mem_rdata : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) owner_q <= OWN_NONE;
    else owner_q <= owner_d;
  assign unused_addr = ^{i_addr[ADDR_W-1:MEM_AW+2], i_addr[1:0],
                         d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0]};
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: randomized scenarios checked against a behavioural arbiter/memory model
module tb_riscv_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int MEM_AW = 12;
  localparam int MAX = 4;
  logic clk = 0, rst_n = 0, i_req = 0, d_req = 0, d_we = 0, mem_ready = 1;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [3:0] d_be = 0;
  logic i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en;
  logic [31:0] i_rdata, d_rdata, mem_wdata;
  logic [3:0] mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0] ram [4096];
  logic [31:0] ref_mem [4096];
  int n_vec = 0, n_err = 0, ms = 0;
  bit pv_i = 0, pv_d = 0, gi = 0, gd = 0;
  logic [31:0] pdata = 0;
  always #5 clk = ~clk;
  riscv_mem_arbiter #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .MAX_D_STREAK(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .d_req(d_req), .d_we(d_we), .d_be(d_be),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .mem_ready(mem_ready), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  // the RAM itself (environment, not the reference)
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we == 4'b0) mem_rdata <= ram[mem_addr];
      else for (int b = 0; b < 4; b++) if (mem_we[b]) ram[mem_addr][8*b+:8] <= mem_wdata[8*b+:8];
    end
  // reference: who should win this cycle given the arbitration rules
  task automatic model_grant(output bit egi, output bit egd);
    egd = rst_n && mem_ready && d_req && !(i_req && ms == MAX);
    egi = rst_n && mem_ready && i_req && !egd;
  endtask
  // reference: advance the word-memory image, pending response and streak count
  task automatic model_commit(input bit egi, input bit egd);
    pv_i = egi;
    pv_d = egd && !d_we;
    pdata = ref_mem[egi ? i_addr[MEM_AW+1:2] : d_addr[MEM_AW+1:2]];
    if (egd && d_we)
      for (int b = 0; b < 4; b++) if (d_be[b]) ref_mem[d_addr[MEM_AW+1:2]][8*b+:8] = d_wdata[8*b+:8];
    if (!i_req || egi) ms = 0;
    else if (egd && ms < MAX) ms++;
  endtask
  task automatic test_reset();
    rst_n = 0; i_req = 1; d_req = 1; d_we = 0; mem_ready = 1; i_addr = 32'h100; d_addr = 32'h200;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if ({i_gnt, d_gnt, mem_en, i_rvalid, d_rvalid} !== 5'b0) begin
        n_err++; $display("FAIL reset_outputs cyc %0d: got %b want 00000", c, {i_gnt, d_gnt, mem_en, i_rvalid, d_rvalid});
      end
    end
    rst_n = 1; #1;
    model_grant(gi, gd);
    n_vec++;
    if ({i_gnt, d_gnt} !== {gi, gd} || {gi, gd} !== 2'b01) begin
      n_err++; $display("FAIL reset_first_grant: got i=%b d=%b want d grant", i_gnt, d_gnt);
    end
    model_commit(gi, gd);
    @(negedge clk);
    i_req = 0; d_req = 0; #1;
    model_grant(gi, gd);
    n_vec++;
    if (d_rvalid !== 1'b1 || d_rdata !== pdata) begin
      n_err++; $display("FAIL reset_first_load: got v=%b %h want v=1 %h", d_rvalid, d_rdata, pdata);
    end
    model_commit(gi, gd);
    @(negedge clk);
  endtask
  task automatic test_i_only();
    ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33;
    ref_mem[0] = 32'h11; ref_mem[1] = 32'h22; ref_mem[2] = 32'h33;
    d_req = 0;
    for (int c = 0; c < 4; c++) begin
      i_req = c < 3; i_addr = 32'(4 * c); #1;
      model_grant(gi, gd);
      n_vec++;
      if (i_gnt !== gi || d_gnt !== 1'b0) begin
        n_err++; $display("FAIL i_only_gnt cyc %0d: got %b want %b", c, i_gnt, gi);
      end
      n_vec++;
      if (i_rvalid !== pv_i || (pv_i && i_rdata !== pdata)) begin
        n_err++; $display("FAIL i_only_resp cyc %0d: got v=%b %h want v=%b %h", c, i_rvalid, i_rdata, pv_i, pdata);
      end
      model_commit(gi, gd);
      @(negedge clk);
    end
  endtask
  task automatic test_contention(input int cycles, input bit stall);
    i_req = 1; d_req = 1; d_we = 0; gi = 0; gd = 0;
    i_addr = $urandom & 32'hFFFF_FFFC; d_addr = $urandom;
    for (int c = 0; c < cycles; c++) begin
      if (gi) i_addr = $urandom & 32'hFFFF_FFFC;
      if (gd) d_addr = $urandom;
      mem_ready = !(stall && c >= 3 && c < 6);
      #1;
      model_grant(gi, gd);
      n_vec++;
      if ({i_gnt, d_gnt, mem_en} !== {gi, gd, gi | gd}) begin
        n_err++; $display("FAIL contention_gnt cyc %0d: got i=%b d=%b en=%b want i=%b d=%b", c, i_gnt, d_gnt, mem_en, gi, gd);
      end
      n_vec++;
      if ({i_rvalid, d_rvalid} !== {pv_i, pv_d} || (pv_i && i_rdata !== pdata) || (pv_d && d_rdata !== pdata)) begin
        n_err++; $display("FAIL contention_resp cyc %0d: got iv=%b %h dv=%b %h want iv=%b dv=%b %h", c, i_rvalid, i_rdata, d_rvalid, d_rdata, pv_i, pv_d, pdata);
      end
      model_commit(gi, gd);
      @(negedge clk);
    end
    i_req = 0; d_req = 0; mem_ready = 1; #1;
    model_grant(gi, gd);
    model_commit(gi, gd);
    @(negedge clk);
  endtask
  task automatic test_store_load();
    ram[16] = 32'h12345678; ref_mem[16] = 32'h12345678;
    for (int k = 0; k < 2; k++) begin
      i_req = 0; d_req = 1; d_we = 1; d_addr = 32'h40;
      d_be = k == 0 ? 4'b0011 : 4'b0000; d_wdata = k == 0 ? 32'hAABBCCDD : 32'hFFFFFFFF; #1;
      model_grant(gi, gd);
      n_vec++;
      if (d_gnt !== 1'b1 || mem_we !== d_be || mem_wdata !== d_wdata || mem_addr !== 12'h010) begin
        n_err++; $display("FAIL store_issue %0d: got gnt=%b we=%b wd=%h a=%h want gnt=1 we=%b wd=%h a=010", k, d_gnt, mem_we, mem_wdata, mem_addr, d_be, d_wdata);
      end
      model_commit(gi, gd);
      @(negedge clk);
      d_we = 0; d_be = 0; #1;
      n_vec++;
      if (d_rvalid !== 1'b0) begin
        n_err++; $display("FAIL store_no_rvalid %0d: got %b want 0", k, d_rvalid);
      end
      model_grant(gi, gd);
      model_commit(gi, gd);
      @(negedge clk);
      d_req = 0; #1;
      n_vec++;
      if (d_rvalid !== 1'b1 || d_rdata !== 32'h1234CCDD || d_rdata !== pdata) begin
        n_err++; $display("FAIL store_then_load %0d: got v=%b %h want v=1 1234ccdd", k, d_rvalid, d_rdata);
      end
      model_grant(gi, gd);
      model_commit(gi, gd);
      @(negedge clk);
    end
  endtask
  task automatic test_mid_reset();
    i_req = 1; d_req = 0; i_addr = 32'h80; #1;
    model_grant(gi, gd);
    n_vec++;
    if (i_gnt !== 1'b1) begin
      n_err++; $display("FAIL midreset_gnt: got %b want 1", i_gnt);
    end
    @(posedge clk); #1;
    rst_n = 0; pv_i = 0; pv_d = 0; ms = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_vec++;
      if ({i_rvalid, i_gnt, mem_en} !== 3'b000) begin
        n_err++; $display("FAIL midreset_drop cyc %0d: got rv=%b gnt=%b en=%b want 000", c, i_rvalid, i_gnt, mem_en);
      end
    end
    rst_n = 1; #1;
    model_grant(gi, gd);
    n_vec++;
    if (i_gnt !== gi || i_rvalid !== 1'b0) begin
      n_err++; $display("FAIL midreset_restart: got gnt=%b rv=%b want gnt=%b rv=0", i_gnt, i_rvalid, gi);
    end
    model_commit(gi, gd);
    @(negedge clk);
    i_req = 0; #1;
    n_vec++;
    if (i_rvalid !== 1'b1 || i_rdata !== pdata) begin
      n_err++; $display("FAIL midreset_data: got v=%b %h want v=1 %h", i_rvalid, i_rdata, pdata);
    end
    model_grant(gi, gd);
    model_commit(gi, gd);
    @(negedge clk);
  endtask
  task automatic test_random();
    gi = 0; gd = 0; d_req = 0; i_req = 0;
    for (int c = 0; c < 400; c++) begin
      if (gd || !d_req) begin
        d_req = ($urandom % 4) != 0; d_we = ($urandom % 3) == 0; d_be = 4'($urandom);
        d_addr = $urandom % 256; d_wdata = $urandom;
      end
      if (gi || !i_req) begin
        i_req = $urandom % 2; i_addr = ($urandom % 256) & 32'hFFFF_FFFC;
      end
      mem_ready = ($urandom % 5) != 0;
      #1;
      model_grant(gi, gd);
      n_vec++;
      if ({i_gnt, d_gnt, mem_en} !== {gi, gd, gi | gd} ||
          ((gi | gd) && mem_addr !== (gd ? d_addr[MEM_AW+1:2] : i_addr[MEM_AW+1:2])) ||
          mem_we !== ((gd && d_we) ? d_be : 4'b0)) begin
        n_err++; $display("FAIL random_issue cyc %0d: got i=%b d=%b a=%h we=%b want i=%b d=%b", c, i_gnt, d_gnt, mem_addr, mem_we, gi, gd);
      end
      n_vec++;
      if ({i_rvalid, d_rvalid} !== {pv_i, pv_d} || (pv_i && i_rdata !== pdata) || (pv_d && d_rdata !== pdata)) begin
        n_err++; $display("FAIL random_resp cyc %0d: got iv=%b %h dv=%b %h want iv=%b dv=%b %h", c, i_rvalid, i_rdata, d_rvalid, d_rdata, pv_i, pv_d, pdata);
      end
      model_commit(gi, gd);
      @(negedge clk);
    end
  endtask
  initial begin
    for (int w = 0; w < 4096; w++) begin
      ram[w] = $urandom; ref_mem[w] = ram[w];
    end
    test_reset();
    test_i_only();
    test_contention(10, 0);
    test_store_load();
    test_contention(14, 1);
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
